// File: rtl/regseq_pkg.sv
// Shared types and widths for the register-file sequencer and its ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regseq_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_LDI = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } state_e;

  // Instruction word layout: [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2.
  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
  } instr_t;

endpackage

// File: rtl/regseq_alu.sv
// Combinational ALU: ADD/SUB/AND on two operands, or pass-through of the immediate.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
module regseq_alu
  import regseq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  op_e               op,
  output logic [DATA_W-1:0] y,
  output logic              carry
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // Select the result; carry is the ninth sum bit for ADD and the borrow for SUB.
  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        y     = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      OP_SUB: begin
        y     = a - b;
        carry = (a < b);
      end
      OP_AND:  y = a & b;
      OP_LDI:  y = imm;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences one instruction through READ/EXEC/WRITE against an external 4x8 register file.
// Latency: transfer at edge N -> WE3 low during cycle N+3; one instruction per 4 cycles.
// Backpressure: INSTR_READY only in IDLE; INSTR_VALID ignored elsewhere. Macro REGSEQ_FLAGS_EN enables ZERO/CARRY.
module regfile_sequencer
  import regseq_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  input  logic [7:0]        INSTR,
  input  logic [DATA_W-1:0] IMM,
  output logic [ADDR_W-1:0] RA1,
  output logic [ADDR_W-1:0] RA2,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  output logic [ADDR_W-1:0] RA3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic              DONE,
  output logic [DATA_W-1:0] RESULT,
  output logic              ZERO,
  output logic              CARRY
);

  state_e            state_q, state_d;
  instr_t            instr_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] alu_y;
  logic              alu_co;

  regseq_alu u_alu (
    .a     (a_q),
    .b     (b_q),
    .imm   (imm_q),
    .op    (instr_q.op),
    .y     (alu_y),
    .carry (alu_co)
  );

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus state-decoded handshake, read-address and write-strobe outputs.
  always_comb begin
    state_d     = state_q;
    INSTR_READY = 1'b0;
    WE3         = 1'b1;
    DONE        = 1'b0;
    RA1         = '0;
    RA2         = '0;
    case (state_q)
      IDLE: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) state_d = READ;
      end
      READ: begin
        RA1     = instr_q.rs1;
        RA2     = instr_q.rs2;
        state_d = EXEC;
      end
      EXEC: state_d = WRITE;
      WRITE: begin
        WE3     = 1'b0;
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch instruction, capture operands, stage write-back, publish result.
  // RA3/WD3 load on entry to WRITE and then hold until the next write-back.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instr_q <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      RA3     <= '0;
      WD3     <= '0;
      RESULT  <= '0;
    end else begin
      case (state_q)
        IDLE: if (INSTR_VALID) begin
          instr_q <= INSTR;
          imm_q   <= IMM;
        end
        READ: begin
          a_q <= RD1;
          b_q <= RD2;
        end
        EXEC: begin
          RA3 <= instr_q.rd;
          WD3 <= alu_y;
        end
        WRITE: RESULT <= WD3;
        default: ;
      endcase
    end
  end

`ifdef REGSEQ_FLAGS_EN
  logic carry_q;

  // Flags: carry is staged with the result in EXEC, both flags publish with RESULT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      carry_q <= 1'b0;
      ZERO    <= 1'b0;
      CARRY   <= 1'b0;
    end else if (state_q == EXEC) begin
      carry_q <= alu_co;
    end else if (state_q == WRITE) begin
      ZERO  <= (WD3 == '0);
      CARRY <= carry_q;
    end
  end
`else
  logic alu_co_unused;

  assign alu_co_unused = alu_co;
  assign ZERO          = 1'b0;
  assign CARRY         = 1'b0;
`endif

endmodule
